// File: rtl/tinyriscv_pkg.sv
// Shared memory-bus types for the tinyriscv memory subsystem and the SRAM bank
// controller state encoding.
package tinyriscv_pkg;

    typedef logic [31:0] MemAddrBus;

    localparam logic WriteEnable = 1'b1;

    typedef enum logic {
        INIT,
        READY
    } sram_bank_state_e;

endpackage

// File: rtl/sram_bank_array.sv
// Single-port storage array with per-byte-lane write enables and a registered
// read port; a lane holds 8 data bits plus its optional parity bit at Width+lane.
module sram_bank_array #(
    parameter int    Depth       = 1024,
    parameter int    Width       = 32,
    parameter int    StoreW      = 32,
    parameter string MemInitFile = ""
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [Width/8-1:0]       be_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [StoreW-1:0]        wdata_i,
    output logic [StoreW-1:0]        rdata_o
);
    localparam int NB = Width / 8;

    logic [StoreW-1:0] mem_q [Depth];
    logic [StoreW-1:0] rdata_q;
    logic [StoreW-1:0] wmask;

    // Parity bits sit above the data word, so shifting the lane enables up by
    // Width selects them; without parity the shift leaves nothing.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) begin
            if (be_i[i]) wmask[8*i +: 8] = 8'hff;
        end
        wmask = wmask | (StoreW'(be_i) << Width);
    end

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= (mem_q[addr_i] & ~wmask) | (wdata_i & wmask);
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bank.sv
// SRAM bank controller: INIT/READY sequencing, range check, response pipeline.
// Optional per-byte even parity is enabled by defining SRAM_BANK_PARITY_EN.
module sram_bank
    import tinyriscv_pkg::*;
#(
    parameter int    Depth       = 1024,
    parameter int    Width       = 32,
    parameter int    ReadLatency = 1,
    parameter string MemInitFile = ""
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic               we_i,
    input  logic [Width/8-1:0] be_i,
    input  MemAddrBus          addr_i,
    input  logic [Width-1:0]   wdata_i,
    output logic               rvalid_o,
    output logic [Width-1:0]   rdata_o,
    output logic               err_o
);
    localparam int NB = Width / 8;
    localparam int AW = $clog2(Depth);
`ifdef SRAM_BANK_PARITY_EN
    localparam int ParBits = 1;
`else
    localparam int ParBits = 0;
`endif
    localparam int StoreW  = Width + NB * ParBits;
    localparam bit Preload = (MemInitFile != "");

    function automatic logic [NB-1:0] lane_parity(input logic [Width-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    sram_bank_state_e state_q;
    logic [AW-1:0]    clr_idx_q;
    logic             gnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            gnt_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (Preload || clr_idx_q == AW'(Depth - 1)) begin
                        state_q <= READY;
                        gnt_q   <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_o = gnt_q;

    logic acc, oor, is_wr;
    assign acc   = req_i & gnt_q;
    assign oor   = |(addr_i >> (AW + 2));
    assign is_wr = (we_i == WriteEnable);

    logic              arr_we, arr_re;
    logic [NB-1:0]     arr_be;
    logic [AW-1:0]     arr_addr;
    logic [StoreW-1:0] arr_wdata, arr_rdata;

    // While clearing, the FSM owns the array port and writes zero data with
    // zero parity, which is consistent even parity for every lane.
    always_comb begin
        arr_we    = acc & is_wr & ~oor;
        arr_re    = acc & ~is_wr & ~oor;
        arr_be    = be_i;
        arr_addr  = addr_i[AW+1:2];
        arr_wdata = StoreW'(wdata_i) | (StoreW'(lane_parity(wdata_i)) << Width);
        if (state_q == INIT) begin
            arr_we    = ~Preload;
            arr_re    = 1'b0;
            arr_be    = '1;
            arr_addr  = clr_idx_q;
            arr_wdata = '0;
        end
    end

    sram_bank_array #(
        .Depth       (Depth),
        .Width       (Width),
        .StoreW      (StoreW),
        .MemInitFile (MemInitFile)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .be_i    (arr_be),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    logic vld_p1_q, rd_p1_q, err_p1_q;
    logic rd_p1_d, err_p1_d;
    assign rd_p1_d  = ~is_wr & ~oor;
    assign err_p1_d = oor;

    // p0 -> p1: accepted request, array read launched
    always_ff @(posedge clk_i) begin
        if (rst_i) vld_p1_q <= 1'b0;
        else       vld_p1_q <= acc;
    end

    always_ff @(posedge clk_i) begin
        rd_p1_q  <= rd_p1_d;
        err_p1_q <= err_p1_d;
    end

    logic [Width-1:0] raw_p1, data_p1;
    logic             par_err_p1, err_p1;

    always_comb begin
        raw_p1     = arr_rdata[Width-1:0];
        par_err_p1 = (ParBits != 0) && (NB'(arr_rdata >> Width) != lane_parity(raw_p1));
        data_p1    = (vld_p1_q && rd_p1_q) ? raw_p1 : '0;
        err_p1     = vld_p1_q && (err_p1_q || (rd_p1_q && par_err_p1));
    end

    if (ReadLatency == 2) begin : g_lat2
        logic             vld_p2_q, err_p2_q;
        logic [Width-1:0] rdata_p2_q;

        // p1 -> p2: extra output register stage
        always_ff @(posedge clk_i) begin
            if (rst_i) vld_p2_q <= 1'b0;
            else       vld_p2_q <= vld_p1_q;
        end

        always_ff @(posedge clk_i) begin
            rdata_p2_q <= data_p1;
            err_p2_q   <= err_p1;
        end

        assign rvalid_o = vld_p2_q;
        assign rdata_o  = vld_p2_q ? rdata_p2_q : '0;
        assign err_o    = vld_p2_q & err_p2_q;
    end else begin : g_lat1
        assign rvalid_o = vld_p1_q;
        assign rdata_o  = data_p1;
        assign err_o    = err_p1;
    end

endmodule

// File: tb/tb_sram_bank.sv
// Scoreboard bench driving two sram_bank instances (ReadLatency 1 and 2) with
// identical stimulus against a word-array reference model.
module tb_sram_bank;
    localparam int Depth = 16;
    localparam int Width = 32;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst_i, req_i, we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i, wdata_i;
    logic        gnt1, rv1, er1, gnt2, rv2, er2;
    logic [31:0] rd1, rd2;

    always #5 clk = ~clk;

    sram_bank #(.Depth(Depth), .Width(Width), .ReadLatency(1), .MemInitFile("")) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt1), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1));

    sram_bank #(.Depth(Depth), .Width(Width), .ReadLatency(2), .MemInitFile("")) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt2), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rv2), .rdata_o(rd2), .err_o(er2));

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q1[$], q2[$];
    logic [31:0] model_mem [Depth];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          corrupt_idx = -1;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int which, input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        bit   empty;
        empty = (which == 1) ? (q1.size() == 0) : (q2.size() == 0);
        if (rv !== 1'b1) begin
            check($sformatf("dut%0d idle_rdata", which), rd, 32'h0);
            check($sformatf("dut%0d idle_err", which), {31'h0, er}, 32'h0);
        end else if (empty) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d unexpected_rvalid: got rvalid=1, expected no response (cycle %0d)", which, cyc);
        end else begin
            e = (which == 1) ? q1.pop_front() : q2.pop_front();
            check($sformatf("dut%0d resp_cycle", which), cyc, e.cyc);
            check($sformatf("dut%0d rdata", which), rd, e.data);
            check($sformatf("dut%0d err", which), {31'h0, er}, {31'h0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, rv1, rd1, er1);
            mon(2, rv2, rd2, er2);
        end
    end

    // Responses due after the current cycle are lost when reset hits.
    task automatic flush_pending();
        exp_t k1[$], k2[$];
        foreach (q1[i]) if (q1[i].cyc <= cyc) k1.push_back(q1[i]);
        foreach (q2[i]) if (q2[i].cyc <= cyc) k2.push_back(q2[i]);
        q1 = k1;
        q2 = k2;
    endtask

    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd);
        int          n = 0;
        int          idx;
        bit          oor;
        logic [31:0] data;
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wd;
        while (!(gnt1 === 1'b1 && gnt2 === 1'b1)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL grant_timeout: got no grant after %0d cycles, expected grant", n);
                req_i = 1'b0;
                return;
            end
        end
        oor  = (addr >> (AW + 2)) != 0;
        idx  = int'((addr >> 2) % Depth);
        data = 32'h0;
        if (!oor) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
                if (idx == corrupt_idx && be[0]) corrupt_idx = -1;
            end else begin
                data = model_mem[idx];
            end
        end
        q1.push_back('{cyc + 1, data, oor || (!we && !oor && idx == corrupt_idx)});
        q2.push_back('{cyc + 2, data, oor || (!we && !oor && idx == corrupt_idx)});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input bit wait_init);
        int n = 0;
        req_i = 1'b0;
        rst_i = 1'b1;
        flush_pending();
        @(negedge clk);
        check("reset gnt1", {31'h0, gnt1}, 32'h0);
        check("reset gnt2", {31'h0, gnt2}, 32'h0);
        check("reset rvalid2", {31'h0, rv2}, 32'h0);
        check("reset rdata1", rd1, 32'h0);
        check("reset err1", {31'h0, er1}, 32'h0);
        mon_en = 1'b1;
        rst_i  = 1'b0;
        for (int i = 0; i < Depth; i++) model_mem[i] = 32'h0;
        corrupt_idx = -1;
        if (wait_init) begin
            while (gnt1 !== 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("init_gnt_low_cycles", n, Depth);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        do_reset(1'b1);

        for (int i = 0; i < Depth; i++) issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
        idle(3);

        issue(1'b1, 4'b1111, 32'h8, 32'hAABBCCDD);
        issue(1'b1, 4'b0101, 32'h8, 32'h11223344);
        issue(1'b0, 4'h0, 32'h8, 32'h0);
        idle(3);

        issue(1'b1, 4'b1111, 32'h1000, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 32'h0, 32'h0);
        issue(1'b0, 4'h0, 32'hB, 32'h0);
        idle(3);

        issue(1'b0, 4'h0, 32'h0, 32'h0);
        issue(1'b0, 4'h0, 32'h4, 32'h0);
        issue(1'b0, 4'h0, 32'h8, 32'h0);
        idle(4);

        issue(1'b1, 4'b1111, 32'h14, 32'h5A5A5A5A);
        do_reset(1'b0);
        idle(5);
        do_reset(1'b1);
        issue(1'b1, 4'b1111, 32'h4, 32'h12345678);
        issue(1'b0, 4'h0, 32'h4, 32'h0);
        do_reset(1'b1);
        for (int i = 0; i < Depth; i++) issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
        idle(3);

        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h40;
            else a = ($urandom_range(0, Depth - 1) << 2) | ($urandom % 4);
            issue(1'($urandom % 2), 4'($urandom), a, $urandom);
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

`ifdef SRAM_BANK_PARITY_EN
        issue(1'b1, 4'b1111, 32'h8, 32'h0F0F0F0F);
        idle(3);
        u_dut1.u_array.mem_q[2][3] = ~u_dut1.u_array.mem_q[2][3];
        u_dut2.u_array.mem_q[2][3] = ~u_dut2.u_array.mem_q[2][3];
        model_mem[2] = model_mem[2] ^ 32'h8;
        corrupt_idx  = 2;
        issue(1'b0, 4'h0, 32'h8, 32'h0);
        issue(1'b0, 4'h0, 32'h4, 32'h0);
        idle(3);
`endif

        idle(4);
        check("dut1 queue_drained", q1.size(), 32'h0);
        check("dut2 queue_drained", q2.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
